// File: rtl/boid_frame_plotter.sv
// boid_frame_plotter
//   Holds X/Y positions for up to MAX_BOIDS boids and redraws them once per
//   VGA frame.  On frame_end (while idle) it pulses fb_clear, snapshots every
//   slot into an active copy, then sweeps slot/dy/dx one step per clock,
//   emitting one frame-buffer write per visible dot pixel.
//
// Ports
//   clock       system clock
//   CPU_RESETN  synchronous active-low reset
//   cpu_we      write strobe: shadow[cpu_idx] <= {cpu_x, cpu_y}
//   cpu_idx     slot index; values >= MAX_BOIDS are ignored
//   cpu_x/cpu_y position written to the slot
//   frame_end   one-cycle pulse from the VGA controller
//   fb_clear    one-cycle pulse to the display RAM clear input
//   fb_we       frame-buffer write enable (data is implicitly 1)
//   fb_addr     pixel address x + SCREEN_W*y; holds when fb_we=0
//   busy        high from the clear cycle through the last write cycle
//   overrun     sticky: frame_end arrived while busy
//
// Handshake: there is no back-pressure.  cpu_we is a single-cycle strobe
// accepted in every state; frame_end is honoured only when busy=0; fb_we is
// a fire-and-forget strobe qualified by itself, one write per cycle.
//
// The FSM state is the internal enumerated signal "state" (IDLE/CLEAR/SWEEP).
module boid_frame_plotter #(
  parameter int MAX_BOIDS = 32,
  parameter int IDX_BITS  = $clog2(MAX_BOIDS),
  parameter int X_BITS    = 10,
  parameter int Y_BITS    = 9,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int ADDR_W    = 19,
  parameter int DOT_SIZE  = 1
) (
  input  logic              clock,
  input  logic              CPU_RESETN,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_idx,
  input  logic [X_BITS-1:0] cpu_x,
  input  logic [Y_BITS-1:0] cpu_y,
  input  logic              frame_end,
  output logic              fb_clear,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SWEEP = 2'd2
  } state_t;

  // Last value of the dx/dy sub-iterators; stays 0 for 1-pixel dots.
  localparam logic DMAX = (DOT_SIZE == 2);
  localparam logic [X_BITS:0]   SW_LIM   = (X_BITS + 1)'(SCREEN_W);
  localparam logic [Y_BITS:0]   SH_LIM   = (Y_BITS + 1)'(SCREEN_H);
  localparam logic [ADDR_W-1:0] SW_MUL   = ADDR_W'(SCREEN_W);
  localparam logic [8:0]        IDX_LIM  = 9'(MAX_BOIDS);
  localparam logic [IDX_BITS-1:0] SLOT_LAST = IDX_BITS'(MAX_BOIDS - 1);

  state_t state, state_next;

  // CPU-facing shadow copy and the frozen copy the sweep reads from.
  logic [X_BITS-1:0]    shadow_x [MAX_BOIDS];
  logic [Y_BITS-1:0]    shadow_y [MAX_BOIDS];
  logic [MAX_BOIDS-1:0] shadow_valid;
  logic [X_BITS-1:0]    active_x [MAX_BOIDS];
  logic [Y_BITS-1:0]    active_y [MAX_BOIDS];
  logic [MAX_BOIDS-1:0] active_valid;

  // Sweep iterator: dx fastest, then dy, then slot.
  logic [IDX_BITS-1:0] slot;
  logic                dx;
  logic                dy;
  logic                last_step;

  // High in the cycle after a SWEEP issue cycle (the output stage cycle).
  logic pend;

  logic                idx_ok;
  logic [X_BITS:0]     px;
  logic [Y_BITS:0]     py;
  logic                cand_ok;
  logic [ADDR_W-1:0]   cand_addr;

  assign idx_ok    = ({1'b0, cpu_idx} < IDX_LIM);
  assign last_step = (slot == SLOT_LAST) && (dx == DMAX) && (dy == DMAX);
  assign busy      = (state != IDLE) || pend;

  // Issue stage: one bit wider than the coordinate so x=max plus dx cannot
  // wrap back on screen.
  assign px        = {1'b0, active_x[slot]} + (X_BITS + 1)'(dx);
  assign py        = {1'b0, active_y[slot]} + (Y_BITS + 1)'(dy);
  assign cand_ok   = active_valid[slot] && (px < SW_LIM) && (py < SH_LIM);
  assign cand_addr = ADDR_W'(px) + SW_MUL * ADDR_W'(py);

  always_comb begin
    state_next = state;
    fb_clear   = 1'b0;
    case (state)
      IDLE:    if (frame_end && !busy) state_next = CLEAR;
      CLEAR: begin
        fb_clear   = 1'b1;
        state_next = SWEEP;
      end
      SWEEP:   if (last_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!CPU_RESETN) begin
      state        <= IDLE;
      shadow_valid <= '0;
      active_valid <= '0;
      slot         <= '0;
      dx           <= 1'b0;
      dy           <= 1'b0;
      pend         <= 1'b0;
      fb_we        <= 1'b0;
      fb_addr      <= '0;
      overrun      <= 1'b0;
    end else begin
      state <= state_next;

      if (cpu_we && idx_ok) shadow_valid[cpu_idx[IDX_BITS-1:0]] <= 1'b1;

      if (state == CLEAR) begin
        // Non-blocking read of the shadow: a write in this very cycle lands
        // in the shadow only and shows up in the next frame.
        active_valid <= shadow_valid;
        slot         <= '0;
        dx           <= 1'b0;
        dy           <= 1'b0;
      end else if (state == SWEEP) begin
        if (dx != DMAX) begin
          dx <= 1'b1;
        end else begin
          dx <= 1'b0;
          if (dy != DMAX) begin
            dy <= 1'b1;
          end else begin
            dy   <= 1'b0;
            slot <= slot + 1'b1;
          end
        end
      end

      pend  <= (state == SWEEP);
      fb_we <= (state == SWEEP) && cand_ok;
      if ((state == SWEEP) && cand_ok) fb_addr <= cand_addr;

      if (frame_end && busy) overrun <= 1'b1;
    end
  end

  // Position payload carries no reset; validity bits alone gate its use.
  always_ff @(posedge clock) begin
    if (cpu_we && idx_ok) begin
      shadow_x[cpu_idx[IDX_BITS-1:0]] <= cpu_x;
      shadow_y[cpu_idx[IDX_BITS-1:0]] <= cpu_y;
    end
    if (CPU_RESETN && (state == CLEAR)) begin
      for (int i = 0; i < MAX_BOIDS; i++) begin
        active_x[i] <= shadow_x[i];
        active_y[i] <= shadow_y[i];
      end
    end
  end

endmodule
